// File: rtl/btn_conditioner_pkg.sv
// Shared UI-block definitions: FSM state encoding, default timing, counter sizing.
package btn_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_e;

  localparam int unsigned DEB_CYC_DEFAULT  = 1_000_000;
  localparam int unsigned LONG_CYC_DEFAULT = 100_000_000;
  localparam int unsigned RPT_CYC_DEFAULT  = 20_000_000;

  // Bits needed to hold 0..n inclusive; at least one bit so a zero threshold still sizes legally
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n == 32'd0) ? 32'd1 : 32'($clog2(n + 32'd1));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives it a cycle to settle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronize, debounce, and derive press/release/long/repeat pulses.
// The release and repeat pulses are named release_pulse / repeat_pulse because
// release and repeat are SystemVerilog keywords.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned DEB_CYC  = DEB_CYC_DEFAULT,
  parameter int unsigned LONG_CYC = LONG_CYC_DEFAULT,
  parameter int unsigned RPT_CYC  = RPT_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int unsigned DEB_W  = cnt_w(DEB_CYC);
  localparam int unsigned HOLD_W = cnt_w(LONG_CYC);
  localparam int unsigned RPT_W  = cnt_w(RPT_CYC);

  logic              btn_s;
  logic [DEB_W-1:0]  deb_cnt;
  logic [DEB_W-1:0]  deb_inc;
  logic              flip_c;
  logic              rise_c;
  logic              fall_c;

  btn_state_e        state;
  btn_state_e        state_d;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_d;
  logic [HOLD_W-1:0] hold_inc;
  logic [RPT_W-1:0]  rpt_cnt;
  logic [RPT_W-1:0]  rpt_d;
  logic [RPT_W-1:0]  rpt_inc;
  logic              long_d;
  logic              rep_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  // Accept a level change once btn_s has disagreed with level for DEB_CYC cycles
  always_comb begin
    deb_inc = deb_cnt + DEB_W'(1);
    flip_c  = (btn_s != level) && (deb_inc == DEB_W'(DEB_CYC));
    rise_c  = flip_c && !level;
    fall_c  = flip_c && level;
  end

  // Debounce counter, debounced level and edge pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt       <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      if ((btn_s == level) || flip_c) begin
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_inc;
      end
      if (flip_c) begin
        level <= ~level;
      end
      press         <= rise_c;
      release_pulse <= fall_c;
    end
  end

  // FSM state, hold/repeat counters and long/repeat pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      rpt_cnt      <= '0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      state        <= state_d;
      hold_cnt     <= hold_d;
      rpt_cnt      <= rpt_d;
      long_press   <= long_d;
      repeat_pulse <= rep_d;
    end
  end

  // Next state; a level fall overrides any threshold reached in the same cycle
  always_comb begin
    state_d  = state;
    hold_d   = hold_cnt;
    rpt_d    = rpt_cnt;
    long_d   = 1'b0;
    rep_d    = 1'b0;
    hold_inc = hold_cnt + HOLD_W'(1);
    rpt_inc  = rpt_cnt + RPT_W'(1);

    if (fall_c) begin
      state_d = IDLE;
      hold_d  = '0;
      rpt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise_c) begin
            state_d = PRESSED;
            hold_d  = '0;
            rpt_d   = '0;
          end
        end
        PRESSED: begin
          if (level) begin
            hold_d = hold_inc;
            if (hold_inc == HOLD_W'(LONG_CYC)) begin
              long_d  = 1'b1;
              state_d = HELD;
              rpt_d   = '0;
            end
          end
        end
        HELD: begin
          if (level && (RPT_CYC != 32'd0)) begin
            if (rpt_inc == RPT_W'(RPT_CYC)) begin
              rep_d = 1'b1;
              rpt_d = '0;
            end else begin
              rpt_d = rpt_inc;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 The block SHALL take parameter DEB_CYC, default 1_000_000, as the number of consecutive stable synchronized samples required to accept a level change (minimum 1).
REQ-002 The block SHALL take parameter LONG_CYC, default 100_000_000, as the debounced-high cycles before a long-press event (minimum 1).
REQ-003 The block SHALL take parameter RPT_CYC, default 20_000_000, as the auto-repeat period after a long press; 0 disables repeat.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge system clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port btn_in, input, 1 bit: raw asynchronous push-button, active-high.
REQ-007 The block SHALL have port level, output, 1 bit: debounced button state.
REQ-008 The block SHALL have port press, output, 1 bit: one-cycle pulse on accepted 0->1.
REQ-009 The block SHALL have port release, output, 1 bit: one-cycle pulse on accepted 1->0.
REQ-010 The block SHALL have port long_press, output, 1 bit: one-cycle pulse when the hold reaches LONG_CYC.
REQ-011 The block SHALL have port repeat, output, 1 bit: one-cycle pulse every RPT_CYC cycles while held past long_press.

Function
REQ-012 btn_in SHALL pass through a 2-flop synchronizer; btn_s is the second flop output.
REQ-013 The debounce counter SHALL clear on any cycle btn_s == level, and increment while btn_s != level.
REQ-014 level SHALL toggle, and the counter SHALL clear, at the edge where btn_s has differed from level for DEB_CYC consecutive cycles; latency from a clean btn_in edge to level = 2 + DEB_CYC edges.
REQ-015 press and release SHALL be registered and asserted in exactly the first cycle level shows its new value; never both in one cycle.
REQ-016 The FSM SHALL have states IDLE, PRESSED and HELD, and SHALL enter IDLE on reset.
REQ-017 IDLE SHALL go to PRESSED on the level rise, clearing the hold counter.
REQ-018 PRESSED SHALL increment the hold counter each cycle level=1; at count LONG_CYC it SHALL assert long_press for one cycle, go to HELD, and clear the repeat counter.
REQ-019 HELD SHALL assert repeat for one cycle each time the repeat counter reaches RPT_CYC, then restart the counter; when RPT_CYC = 0 it SHALL stay in HELD without pulses.
REQ-020 Any state SHALL return to IDLE on the level fall, with counters cleared, and SHALL emit no long_press or repeat in that cycle; release takes priority over a coincident threshold.
REQ-021 Counters SHALL be sized $clog2(param+1), SHALL never wrap, and SHALL hold at threshold if not cleared.
REQ-022 A btn_s pulse shorter than DEB_CYC cycles SHALL produce no output activity.

Reset
REQ-023 rst SHALL asynchronously clear the synchronizer flops, all counters, level, press, release, long_press and repeat to 0, and set the FSM to IDLE.
REQ-024 If btn_in is high when rst deasserts, press SHALL follow after 2 + DEB_CYC edges, the same as a fresh press.

Structure
REQ-025 State encodings (IDLE=2'd0, PRESSED=2'd1, HELD=2'd2) and the default timing constants SHALL reside in the shared project package/include, for use by other UI blocks.
REQ-026 The synchronizer SHALL be a separate sub-module sync_2ff (clk, rst, d, q); debounce, FSM and pulse logic SHALL remain in btn_conditioner.

Verification (DEB_CYC=4, LONG_CYC=20, RPT_CYC=8)
REQ-027 Bounce: toggle btn_in every 2 cycles for 12 cycles, then hold high -> exactly one press, with level rising 6 edges after the final rising edge.
REQ-028 Short press: hold 10 cycles after level rises, then release -> one press and one release; no long_press or repeat.
REQ-029 Long hold: hold 45 cycles after level rises -> long_press at cycle 20, repeat at cycles 28, 36 and 44; none after release.
REQ-030 Glitch: 3-cycle high pulse on btn_in -> level stays 0 and all pulses stay 0.
REQ-031 Reset mid-hold: assert rst in HELD -> all outputs 0 same cycle; deassert with btn_in high -> press 6 edges later.
REQ-032 Coincidence: release timed so the level fall lands on hold cycle 20 -> release only, long_press stays 0, FSM in IDLE.
